sprite_rom_reader: RTL
======================

Name: sprite_rom_reader

Overview:
Read-side client of a single-port sprite ROM: 8-bit pixels, 31x27 = 837 entries, registered output with 1-cycle read latency. From the raster position of the 25 MHz VGA pixel stream it generates ROM addresses, tracks sprite rows, and realigns the returned pixel data with a hit flag. The sprite position is latched once per frame. It sits between the VGA sync counter and the pixel mux, one instance per sprite.

Parameters:
SPR_W, 31, sprite width in pixels
SPR_H, 27, sprite height in lines
ADDR_W, 10, ROM address width (2^10 >= SPR_W*SPR_H)
DATA_W, 8, ROM pixel width
H_LAST, 799, last horizontal count of a line (incl. blanking)
V_LAST, 524, last vertical count of a frame
TRANSPARENT, 8'h00, pixel value treated as see-through

Ports:
i_clk2  in  1  25 MHz pixel clock
i_rst  in  1  synchronous reset, active-high
i_xpos  in  10  raster horizontal count, 0..H_LAST
i_ypos  in  10  raster vertical count, 0..V_LAST
i_active  in  1  visible-area flag from VGA sync
i_spr_x  in  10  sprite top-left x (game logic; may change any cycle)
i_spr_y  in  10  sprite top-left y
o_romaddr  out  ADDR_W  address to sprite ROM
i_romdata  in  DATA_W  registered data from ROM, valid 1 cycle after o_romaddr
o_pixel  out  DATA_W  sprite pixel, 0 when o_pix_valid=0
o_pix_valid  out  1  sprite opaque pixel present at the delayed raster position

Behaviour:
- Frame boundary: the cycle with i_xpos==H_LAST && i_ypos==V_LAST.
  - Latch r_x<=i_spr_x, r_y<=i_spr_y; row_base<=0; row_cnt<=0; state<=WAIT.
  - i_spr_x/i_spr_y are ignored on all other cycles (tear-free).
- State machine:
  - IDLE -> WAIT on frame boundary only.
  - WAIT -> DRAW at the cycle i_ypos==r_y.
  - In DRAW, on each i_xpos==H_LAST: row_base<=row_base+SPR_W, row_cnt++. If row_cnt==SPR_H-1, go to DONE instead.
  - DONE -> WAIT on frame boundary.
  - Frame boundary forces WAIT from any non-IDLE state.
- Hit: in_x = (i_xpos>=r_x) && (i_xpos<r_x+SPR_W); in_y = (i_ypos>=r_y) && (i_ypos<r_y+SPR_H). Compute sums at 11 bits so there is no wrap.
  - hit0 = in_x && in_y && i_active && state!=IDLE.
- Pipeline, with raster sample at edge t:
  - Stage 1 (t+1): o_romaddr <= row_base + (i_xpos-r_x) truncated to ADDR_W; hit1<=hit0. o_romaddr holds its value when hit0=0.
  - Stage 2 (t+2): ROM returns data; hit2<=hit1.
  - Stage 3 (t+3): o_pix_valid <= hit2 && (i_romdata!=TRANSPARENT); o_pixel <= o_pix_valid-next ? i_romdata : 0.
  - Total latency: 3 cycles. The downstream mux delays its own raster/sync by 3.
- Clipping: a sprite extending past the visible area is clipped by i_active. Row advance uses H_LAST, so it is correct for any r_x.
  - r_y+SPR_H > V_LAST: rows simply never complete; DONE is not reached; the next frame boundary recovers.
- Reset mid-frame: state IDLE, r_x=r_y=0, row_base=0, row_cnt=0, hit1=hit2=0, o_romaddr=0, o_pixel=0, o_pix_valid=0.
  - Nothing is drawn until after the next frame boundary. No partial sprite.
- Address never exceeds SPR_W*SPR_H-1 while hit1=1.

Decomposition:
- Shared package vga_pkg: H_LAST, V_LAST, H_VISIBLE=640, V_VISIBLE=480, PIX_LATENCY=3, TRANSPARENT.
- Per-sprite sizes stay as parameters.
- No sub-module. The ROM is instantiated beside this block, not inside it, so one reader type serves every sprite ROM.

Test Plan:
- Reset, frame boundary with spr=(100,50), ROM model returns addr[7:0]+1 -> raster (100,50) gives o_romaddr=0 at t+1; o_pix_valid=1, o_pixel=8'h01 at t+3.
- Same frame, (130,50) -> addr 30, valid at t+3; (131,50) and (99,50) -> o_pix_valid=0.
- (100,51) -> addr 31; (130,76) -> addr 836; (100,77) -> no hit; state DONE after line 76 ends.
- ROM returns 8'h00 at addr 5 -> o_pix_valid=0, o_pixel=0 at raster (105,50)+3.
- i_spr_x changed to 200 mid-frame -> current frame still draws at x=100; next frame at x=200.
- spr=(620,0), assert i_rst at (625,3) for one cycle -> outputs 0 immediately, no hits rest of frame; next frame row 1 starts at addr 31, (639,1) gives addr 50, x>=640 suppressed by i_active.

Source files
------------

// File: rtl/vga_pkg.sv
// Raster timing constants and helpers shared by the VGA pixel-path blocks.
// Also holds the sprite reader's state encodings.
package vga_pkg;

  localparam int H_LAST      = 799;
  localparam int V_LAST      = 524;
  localparam int H_VISIBLE   = 640;
  localparam int V_VISIBLE   = 480;
  localparam int PIX_LATENCY = 3;

  localparam logic [7:0] TRANSPARENT = 8'h00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAW = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // 11-bit compare so lo+len never wraps for any 10-bit position
  function automatic logic in_span(input logic [10:0] pos,
                                   input logic [10:0] lo,
                                   input logic [10:0] len);
    return (pos >= lo) && (pos < (lo + len));
  endfunction

endpackage

// File: rtl/sprite_rom_reader.sv
// Sprite ROM read client: raster position -> ROM address -> realigned pixel + hit.
// Latency 3 cycles raster-to-pixel; no backpressure, follows the free-running pixel stream.
module sprite_rom_reader
  import vga_pkg::*;
#(
  parameter int SPR_W  = 31,
  parameter int SPR_H  = 27,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              i_clk2,
  input  logic              i_rst,
  input  logic [9:0]        i_xpos,
  input  logic [9:0]        i_ypos,
  input  logic              i_active,
  input  logic [9:0]        i_spr_x,
  input  logic [9:0]        i_spr_y,
  output logic [ADDR_W-1:0] o_romaddr,
  input  logic [DATA_W-1:0] i_romdata,
  output logic [DATA_W-1:0] o_pixel,
  output logic              o_pix_valid
);

  localparam int CNT_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [1:0]        state;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [ADDR_W-1:0] row_base;
  logic [CNT_W-1:0]  row_cnt;
  logic              hit1;
  logic              hit2;

  logic              frame_end;
  logic              line_end;
  logic              in_x;
  logic              in_y;
  logic              hit0;
  logic              opaque;
  logic [10:0]       x_off;

  assign line_end  = (i_xpos == 10'(H_LAST));
  assign frame_end = line_end && (i_ypos == 10'(V_LAST));

  assign in_x   = in_span({1'b0, i_xpos}, {1'b0, r_x}, 11'(SPR_W));
  assign in_y   = in_span({1'b0, i_ypos}, {1'b0, r_y}, 11'(SPR_H));
  assign hit0   = in_x && in_y && i_active && (state != ST_IDLE);
  assign x_off  = {1'b0, i_xpos} - {1'b0, r_x};
  assign opaque = hit2 && (i_romdata != DATA_W'(TRANSPARENT));

  // Position is sampled only at the frame boundary so a sprite never tears mid-frame.
  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      r_x      <= '0;
      r_y      <= '0;
      row_base <= '0;
      row_cnt  <= '0;
    end else if (frame_end) begin
      state    <= ST_WAIT;
      r_x      <= i_spr_x;
      r_y      <= i_spr_y;
      row_base <= '0;
      row_cnt  <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (i_ypos == r_y) state <= ST_DRAW;
        end
        ST_DRAW: begin
          if (line_end) begin
            if (row_cnt == CNT_W'(SPR_H - 1)) begin
              state <= ST_DONE;
            end else begin
              row_base <= row_base + ADDR_W'(SPR_W);
              row_cnt  <= row_cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address is only refreshed on a hit, so the ROM sees no toggling outside the sprite.
  always_ff @(posedge i_clk2) begin
    if (i_rst) begin
      hit1        <= 1'b0;
      hit2        <= 1'b0;
      o_romaddr   <= '0;
      o_pixel     <= '0;
      o_pix_valid <= 1'b0;
    end else begin
      hit1 <= hit0;
      hit2 <= hit1;
      if (hit0) o_romaddr <= row_base + ADDR_W'(x_off);
      o_pix_valid <= opaque;
      o_pixel     <= opaque ? i_romdata : '0;
    end
  end

endmodule
